// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owner of the single register-file write port (A3/WE3/WD3).
// Optionally clears x1..x31 after reset, then muxes core writeback (priority) with a
// debug/loader req/ack port. A blocked debug request wins once it has waited STARVE_LIMIT
// cycles, stalling the core for that one cycle.
// Optional feature macro: REGFILE_CLEAR_EN (defined: post-reset clear sequence of x1..x31;
// undefined: reset enters RUN directly and init_done rises one cycle after reset release).

module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_we,
  input  logic [4:0]  core_rd,
  input  logic [31:0] core_wd,
  output logic        core_stall,
  input  logic        dbg_req,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic        init_done,
  output logic [4:0]  rf_a3,
  output logic        rf_we3,
  output logic [31:0] rf_wd3
);

  // Keep the counter at least one bit wide so STARVE_LIMIT=0 still elaborates.
  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] LimitVal = CntW'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    StClear,
    StRun
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] wait_cnt_q;
  logic            dbg_ack_q;
  logic            init_done_q;
`ifdef REGFILE_CLEAR_EN
  logic [4:0]      clr_addr_q;
`endif

  logic in_run;
  logic core_real;
  logic force_win;
  logic grant;

  // Arbitration: debug wins when the core is not really writing, or once it has starved.
  always_comb begin
    in_run    = (state_q == StRun);
    core_real = core_we & (core_rd != 5'd0);
    force_win = (wait_cnt_q == LimitVal);
    grant     = in_run & dbg_req & ~dbg_ack_q & (~core_real | force_win);
  end

  // Write-port mux and core stall; reset forces the port idle and the core held.
  always_comb begin
    rf_a3      = core_rd;
    rf_wd3     = core_wd;
    rf_we3     = 1'b0;
    core_stall = 1'b1;
    if (!rst_n) begin
      rf_we3     = 1'b0;
      core_stall = 1'b1;
`ifdef REGFILE_CLEAR_EN
    end else if (!in_run) begin
      rf_a3      = clr_addr_q;
      rf_wd3     = 32'd0;
      rf_we3     = 1'b1;
      core_stall = 1'b1;
`endif
    end else if (grant) begin
      rf_a3      = dbg_addr;
      rf_wd3     = dbg_wdata;
      rf_we3     = (dbg_addr != 5'd0);
      // Only a forced win over a real core write costs the core a cycle.
      core_stall = force_win & core_real;
    end else begin
      rf_a3      = core_rd;
      rf_wd3     = core_wd;
      rf_we3     = core_real;
      core_stall = 1'b0;
    end
  end

  // Control FSM: clear sequencing, starvation counter, registered ack and init flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef REGFILE_CLEAR_EN
      state_q    <= StClear;
      clr_addr_q <= 5'd1;
`else
      state_q    <= StRun;
`endif
      wait_cnt_q  <= '0;
      dbg_ack_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          dbg_ack_q <= 1'b0;
`ifdef REGFILE_CLEAR_EN
          clr_addr_q <= clr_addr_q + 5'd1;
          if (clr_addr_q == 5'd31) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end
`else
          state_q     <= StRun;
          init_done_q <= 1'b1;
`endif
        end
        StRun: begin
          init_done_q <= 1'b1;
          dbg_ack_q   <= grant;
          if (grant) begin
            wait_cnt_q <= '0;
          end else if (dbg_req && !dbg_ack_q && (wait_cnt_q != LimitVal)) begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign dbg_ack   = dbg_ack_q;
  assign init_done = init_done_q;

`ifndef SYNTHESIS
  // x0 is hardwired zero; the port must never target it.
  always_comb begin
    if (rst_n && rf_we3) begin
      assert (rf_a3 != 5'd0);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a driver issues random core/debug traffic,
// a request-level reference model pushes expected writes, acks and per-cycle status into
// queues, and a negedge monitor pops and compares what the DUT presents.

module tb_regfile_write_arbiter;

  localparam int Limit = 4;
`ifdef REGFILE_CLEAR_EN
  localparam int ClearCycles = 31;
  localparam int InitAt      = 31;
`else
  localparam int ClearCycles = 0;
  localparam int InitAt      = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_we = 1'b0;
  logic [4:0]  core_rd = '0;
  logic [31:0] core_wd = '0;
  logic        core_stall;
  logic        dbg_req = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ack;
  logic        init_done;
  logic [4:0]  rf_a3;
  logic        rf_we3;
  logic [31:0] rf_wd3;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_we    (core_we),
    .core_rd    (core_rd),
    .core_wd    (core_wd),
    .core_stall (core_stall),
    .dbg_req    (dbg_req),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_ack    (dbg_ack),
    .init_done  (init_done),
    .rf_a3      (rf_a3),
    .rf_we3     (rf_we3),
    .rf_wd3     (rf_wd3)
  );

  typedef struct {int cyc; bit stall; bit init;} cyc_rec_t;
  typedef struct {int cyc; logic [4:0] a3; logic [31:0] wd;} wr_rec_t;

  cyc_rec_t cyc_q[$];
  wr_rec_t  wr_q[$];
  int       ack_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state, in request-level terms.
  int m_j       = 0;   // cycles since reset release
  bit m_ack     = 0;   // an ack is due in the current cycle
  int m_blocked = 0;   // cycles the outstanding debug request has been refused
  bit pend      = 0;   // driver has a request not yet granted

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step(output bit granted);
    cyc_rec_t c;
    wr_rec_t  w;
    bit core_real, dbg_wants, win;
    granted = 0;
    c.cyc   = cyc;
    c.stall = 1;
    c.init  = 0;
    if (!rst_n) begin
      m_j = 0; m_ack = 0; m_blocked = 0;
    end else begin
      c.init = (m_j >= InitAt);
      if (m_ack) ack_q.push_back(cyc);
      if (m_j < ClearCycles) begin
        w.cyc = cyc; w.a3 = 5'(m_j + 1); w.wd = 32'd0;
        wr_q.push_back(w);
        m_ack = 0;
      end else begin
        core_real = core_we && (core_rd != 0);
        dbg_wants = dbg_req && !m_ack;
        win       = dbg_wants && (!core_real || m_blocked >= Limit);
        c.stall   = win && core_real;
        m_ack     = win;
        granted   = win;
        if (win) begin
          m_blocked = 0;
          if (dbg_addr != 0) begin
            w.cyc = cyc; w.a3 = dbg_addr; w.wd = dbg_wdata;
            wr_q.push_back(w);
          end
        end else begin
          if (core_real) begin
            w.cyc = cyc; w.a3 = core_rd; w.wd = core_wd;
            wr_q.push_back(w);
          end
          if (dbg_wants && m_blocked < Limit) m_blocked++;
        end
      end
      m_j++;
    end
    cyc_q.push_back(c);
  endtask

  // mode 0: light core traffic, 1: core hammers x10 (starvation), 2: x0-heavy,
  // 3: fully random, 4: quiet (no core writes, no new requests).
  task automatic drive(input bit r, input int mode);
    bit granted;
    @(posedge clk);
    #1;
    cyc++;
    rst_n   = r;
    core_wd = $urandom();
    case (mode)
      0: begin core_we = ($urandom_range(3) == 0); core_rd = 5'($urandom_range(31)); end
      1: begin core_we = 1'b1; core_rd = 5'd10; end
      2: begin
        core_we = ($urandom_range(1) != 0);
        core_rd = ($urandom_range(1) != 0) ? 5'd0 : 5'($urandom_range(31));
      end
      4: begin core_we = 1'b0; core_rd = 5'($urandom_range(31)); end
      default: begin core_we = ($urandom_range(1) != 0); core_rd = 5'($urandom_range(31)); end
    endcase
    if (!r) pend = 0;
    if (!pend && mode != 4 && $urandom_range(1) != 0) begin
      pend = 1;
      // In an ack cycle, sometimes keep addr/data: the request is simply held through.
      if (!(m_ack && $urandom_range(1) != 0)) begin
        dbg_wdata = $urandom();
        case (mode)
          1:       dbg_addr = 5'd7;
          2:       dbg_addr = ($urandom_range(1) != 0) ? 5'd0 : 5'($urandom_range(31));
          default: dbg_addr = 5'($urandom_range(31));
        endcase
      end
    end
    dbg_req = pend;
    model_step(granted);
    if (granted) pend = 0;
  endtask

  // Monitor: per-cycle status every cycle, writes/acks only when the DUT presents them.
  always @(negedge clk) begin
    cyc_rec_t c;
    wr_rec_t  w;
    int       a;
    if (cyc_q.size() != 0) begin
      c = cyc_q.pop_front();
      chk("core_stall", 32'(core_stall), 32'(c.stall));
      chk("init_done", 32'(init_done), 32'(c.init));
      if (rf_we3) begin
        if (wr_q.size() == 0) begin
          chk("unexpected write", 32'(rf_we3), 32'd0);
        end else begin
          w = wr_q.pop_front();
          chk("write cycle", 32'(cyc), 32'(w.cyc));
          chk("rf_a3", 32'(rf_a3), 32'(w.a3));
          chk("rf_wd3", rf_wd3, w.wd);
        end
      end
      while (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
        void'(wr_q.pop_front());
        chk("write missing", 32'(rf_we3), 32'd1);
      end
      if (dbg_ack) begin
        if (ack_q.size() == 0) begin
          chk("unexpected dbg_ack", 32'(dbg_ack), 32'd0);
        end else begin
          a = ack_q.pop_front();
          chk("dbg_ack cycle", 32'(cyc), 32'(a));
        end
      end
      while (ack_q.size() != 0 && ack_q[0] <= cyc) begin
        void'(ack_q.pop_front());
        chk("dbg_ack missing", 32'(dbg_ack), 32'd1);
      end
    end
  end

  initial begin
    repeat (3) drive(0, 0);
    // Reset again while the clear sequence would be writing x12.
    for (int i = 0; i < 11; i++) drive(1, 0);
    repeat (2) drive(0, 0);
    for (int i = 0; i < 60; i++) drive(1, 0);
    for (int i = 0; i < 40; i++) drive(1, 1);
    for (int i = 0; i < 60; i++) drive(1, 2);
    for (int i = 0; i < 300; i++) drive($urandom_range(63) != 0, 3);
    for (int i = 0; i < 40; i++) drive(1, 1);
    for (int i = 0; i < 8; i++) drive(1, 4);
    @(posedge clk);
    #1;
    dbg_req = 1'b0;
    core_we = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("write queue drained", 32'(wr_q.size()), 32'd0);
    chk("ack queue drained", 32'(ack_q.size()), 32'd0);
    chk("status queue drained", 32'(cyc_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
